// File: rtl/sift_stage_sequencer_if.sv
// Stage-side bundle of the SIFT stage sequencer: start/done handshake plus the
// per-stage shared-memory buses and the muxed memory-side buses.
interface sift_stage_sequencer_if #(
   parameter int NUM_STAGES = 3,
   parameter int NUM_MEMS   = 4,
   parameter int ADDR_W     = 9
);
   logic [NUM_STAGES-1:0]                 stage_start;
   logic [NUM_STAGES-1:0]                 stage_done;
   logic [NUM_STAGES*NUM_MEMS*ADDR_W-1:0] stage_addr;
   logic [NUM_STAGES*NUM_MEMS-1:0]        stage_we;
   logic [NUM_MEMS*ADDR_W-1:0]            mem_addr;
   logic [NUM_MEMS-1:0]                   mem_we;

   modport master (
      output stage_start, mem_addr, mem_we,
      input  stage_done, stage_addr, stage_we
   );

   modport slave (
      input  stage_start, mem_addr, mem_we,
      output stage_done, stage_addr, stage_we
   );
endinterface

// File: rtl/sift_stage_sequencer.sv
// Sequences the enabled SIFT stages in index order with a start/done handshake,
// muxes the active stage onto the shared memories and guards each stage with a
// watchdog. Optional per-stage RUN-cycle counters under SIFT_SEQ_PERF_EN.
module sift_stage_sequencer #(
   parameter int NUM_STAGES     = 3,
   parameter int NUM_MEMS       = 4,
   parameter int ADDR_W         = 9,
   parameter int CNT_W          = 11,
   parameter int LATCH_STAGE    = 1,
   parameter int TIMEOUT_CYCLES = 4194303
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          abort,
   input  logic [NUM_STAGES-1:0]         stage_mask,
   input  logic [CNT_W-1:0]              count_in,
   sift_stage_sequencer_if.master        bus,
   output logic [$clog2(NUM_STAGES):0]   cur_stage,
   output logic [CNT_W-1:0]              count_out,
   output logic                          busy,
   output logic                          done,
   output logic                          error,
   output logic [$clog2(NUM_STAGES)-1:0] err_stage
`ifdef SIFT_SEQ_PERF_EN
   ,
   output logic [NUM_STAGES*32-1:0]      perf_cycles
`endif
);

   localparam int IDX_W = $clog2(NUM_STAGES);
   localparam int CUR_W = IDX_W + 1;
   localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CUR_W-1:0] NONE      = '1;
   localparam logic [IDX_W-1:0] LATCH_IDX = IDX_W'(LATCH_STAGE);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RUN  = 3'd1,
      S_GAP  = 3'd2,
      S_FIN  = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   state_t                  state_r;
   logic [NUM_STAGES-1:0]   mask_r;
   logic [IDX_W-1:0]        k_r;
   logic [WD_W-1:0]         wd_r;
   logic [NUM_STAGES-1:0]   stage_start_r;
   logic [CUR_W-1:0]        cur_stage_r;
   logic [CNT_W-1:0]        count_r;
   logic                    busy_r;
   logic                    done_r;
   logic                    error_r;
   logic [IDX_W-1:0]        err_stage_r;

   logic [CUR_W-1:0]           first_s;
   logic [CUR_W-1:0]           gap_next_s;
   logic                       accept_s;
   logic                       timeout_s;
   logic [NUM_MEMS*ADDR_W-1:0] mem_addr_s;
   logic [NUM_MEMS-1:0]        mem_we_s;

   // Lowest enabled stage at or above 'from'; all-ones when there is none.
   function automatic logic [CUR_W-1:0] next_stage(input logic [NUM_STAGES-1:0] mask,
                                                    input int from);
      logic [CUR_W-1:0] r;
      r = NONE;
      for (int s = NUM_STAGES - 1; s >= 0; s--) begin
         if (mask[s] && (s >= from)) begin
            r = CUR_W'(s);
         end
      end
      return r;
   endfunction

   function automatic logic [NUM_STAGES-1:0] onehot(input logic [CUR_W-1:0] idx);
      logic [NUM_STAGES-1:0] r;
      for (int s = 0; s < NUM_STAGES; s++) begin
         r[s] = (idx == CUR_W'(s));
      end
      return r;
   endfunction

   assign first_s    = next_stage(stage_mask, 0);
   assign gap_next_s = next_stage(mask_r, int'(k_r) + 1);
   assign accept_s   = start && ((state_r == S_IDLE) || (state_r == S_ERR));
   assign timeout_s  = WD_EN && (wd_r == WD_LAST);

   // Memory mux driven from the registered stage index; idle/gap/error drive zero.
   always_comb begin
      mem_addr_s = '0;
      mem_we_s   = '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
         mem_addr_s = mem_addr_s | ((cur_stage_r == CUR_W'(s)) ?
                      bus.stage_addr[s*NUM_MEMS*ADDR_W +: NUM_MEMS*ADDR_W] : '0);
         mem_we_s   = mem_we_s | ((cur_stage_r == CUR_W'(s)) ?
                      bus.stage_we[s*NUM_MEMS +: NUM_MEMS] : '0);
      end
   end

   // Sequencer FSM; abort outranks start, done and the watchdog.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= S_IDLE;
         mask_r        <= '0;
         k_r           <= '0;
         wd_r          <= '0;
         stage_start_r <= '0;
         cur_stage_r   <= NONE;
         count_r       <= '0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         error_r       <= 1'b0;
         err_stage_r   <= '0;
      end else if (abort) begin
         state_r       <= S_IDLE;
         wd_r          <= '0;
         stage_start_r <= '0;
         cur_stage_r   <= NONE;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         error_r       <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            S_IDLE, S_ERR: begin
               if (accept_s) begin
                  mask_r  <= stage_mask;
                  error_r <= 1'b0;
                  busy_r  <= 1'b1;
                  if (first_s == NONE) begin
                     state_r <= S_FIN;
                     done_r  <= 1'b1;
                  end else begin
                     state_r       <= S_RUN;
                     k_r           <= first_s[IDX_W-1:0];
                     cur_stage_r   <= first_s;
                     stage_start_r <= onehot(first_s);
                     wd_r          <= '0;
                  end
               end else begin
                  state_r <= state_r;
               end
            end
            S_RUN: begin
               if (bus.stage_done[k_r]) begin
                  state_r       <= S_GAP;
                  stage_start_r <= '0;
                  cur_stage_r   <= NONE;
                  if (k_r == LATCH_IDX) begin
                     count_r <= count_in;
                  end else begin
                     count_r <= count_r;
                  end
               end else if (timeout_s) begin
                  state_r       <= S_ERR;
                  stage_start_r <= '0;
                  cur_stage_r   <= NONE;
                  busy_r        <= 1'b0;
                  error_r       <= 1'b1;
                  err_stage_r   <= k_r;
               end else begin
                  wd_r <= wd_r + WD_W'(1);
               end
            end
            // One idle cycle between stages so each sub-block sees its start drop.
            S_GAP: begin
               if (gap_next_s == NONE) begin
                  state_r <= S_FIN;
                  done_r  <= 1'b1;
               end else begin
                  state_r       <= S_RUN;
                  k_r           <= gap_next_s[IDX_W-1:0];
                  cur_stage_r   <= gap_next_s;
                  stage_start_r <= onehot(gap_next_s);
                  wd_r          <= '0;
               end
            end
            S_FIN: begin
               state_r <= S_IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r       <= S_IDLE;
               stage_start_r <= '0;
               cur_stage_r   <= NONE;
               busy_r        <= 1'b0;
            end
         endcase
      end
   end

   assign bus.stage_start = stage_start_r;
   assign bus.mem_addr    = mem_addr_s;
   assign bus.mem_we      = mem_we_s;
   assign cur_stage       = cur_stage_r;
   assign count_out       = count_r;
   assign busy            = busy_r;
   assign done            = done_r;
   assign error           = error_r;
   assign err_stage       = err_stage_r;

`ifdef SIFT_SEQ_PERF_EN
   logic [NUM_STAGES*32-1:0] perf_r;

   // Per-stage RUN-cycle counters; a new run clears all, so skipped stages read 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_r <= '0;
      end else if (abort) begin
         perf_r <= perf_r;
      end else if (accept_s) begin
         perf_r <= '0;
      end else if (state_r == S_RUN) begin
         for (int s = 0; s < NUM_STAGES; s++) begin
            if ((k_r == IDX_W'(s)) && (perf_r[s*32 +: 32] != 32'hFFFF_FFFF)) begin
               perf_r[s*32 +: 32] <= perf_r[s*32 +: 32] + 32'd1;
            end else begin
               perf_r[s*32 +: 32] <= perf_r[s*32 +: 32];
            end
         end
      end else begin
         perf_r <= perf_r;
      end
   end

   assign perf_cycles = perf_r;
`endif

endmodule

// File: tb/tb_sift_stage_sequencer.sv
// Randomised bench for sift_stage_sequencer: each run is turned into an expected
// timeline (stage windows, gaps, done/error cycles) and compared every cycle.
module tb_sift_stage_sequencer;
   localparam int NS = 3;
   localparam int NM = 4;
   localparam int AW = 9;
   localparam int CW = 11;
   localparam int LS = 1;
   localparam int TO = 16;
   localparam int H  = 64;
   localparam logic [2:0] NONE = 3'b111;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [NS-1:0] stage_mask = '0;
   logic [CW-1:0] count_in = '0;
   logic [2:0]    cur_stage;
   logic [CW-1:0] count_out;
   logic          busy;
   logic          done;
   logic          error;
   logic [1:0]    err_stage;
`ifdef SIFT_SEQ_PERF_EN
   logic [NS*32-1:0] perf_cycles;
`endif

   sift_stage_sequencer_if #(.NUM_STAGES(NS), .NUM_MEMS(NM), .ADDR_W(AW)) bus ();

   sift_stage_sequencer #(
      .NUM_STAGES(NS), .NUM_MEMS(NM), .ADDR_W(AW), .CNT_W(CW),
      .LATCH_STAGE(LS), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .stage_mask(stage_mask), .count_in(count_in), .bus(bus),
      .cur_stage(cur_stage), .count_out(count_out), .busy(busy), .done(done),
      .error(error), .err_stage(err_stage)
`ifdef SIFT_SEQ_PERF_EN
      , .perf_cycles(perf_cycles)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int sc      = 0;

   logic          m_err   = 1'b0;
   logic [1:0]    m_errst = 2'd0;
   logic [CW-1:0] m_count = '0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One run: start at cycle 0, then H cycles of scheduled stimulus and checks.
   task automatic run_scenario(input logic [2:0] mask, input int d0, input int d1, input int d2,
                               input int abort_at, input bit noise, input bit pin_mux,
                               input int force_cnt);
      int            d [NS];
      logic [2:0]    e_start [H];
      logic [2:0]    e_cur [H];
      bit            e_busy [H];
      bit            e_done [H];
      bit            e_err [H];
      logic [1:0]    e_errst [H];
      logic [CW-1:0] e_cnt [H];
      logic [CW-1:0] cin [H];
      logic [2:0]    sdone [H];
      logic [2:0]    mk [H];
      bit            st [H];
      bit            ab [H];
      int            e_perf [NS];
      logic [NS*NM*AW-1:0] saddr;
      logic [NS*NM-1:0]    swe;
      logic [NM*AW-1:0]    xa;
      logic [NM-1:0]       xw;
      int t, latch_c, run_len, ec;
      bit stopped;
      string sfx;

      d[0] = d0; d[1] = d1; d[2] = d2;
      for (int c = 0; c < H; c++) begin
         e_start[c] = 3'b000; e_cur[c] = NONE; e_busy[c] = 1'b0; e_done[c] = 1'b0;
         e_err[c] = (c == 0) ? m_err : 1'b0; e_errst[c] = m_errst;
         cin[c] = (force_cnt >= 0) ? CW'(force_cnt) : CW'($urandom);
         sdone[c] = 3'b000; st[c] = 1'b0; ab[c] = 1'b0;
         mk[c] = noise ? 3'($urandom) : mask;
      end
      for (int k = 0; k < NS; k++) e_perf[k] = 0;
      st[0] = 1'b1; mk[0] = mask;

      // Timeline: stage k owns the cycles [t, t+d]; one gap; last done -> FIN.
      t = 1; latch_c = -1; stopped = 1'b0;
      for (int k = 0; k < NS; k++) begin
         if (mask[k] && !stopped) begin
            run_len = (d[k] < TO) ? d[k] + 1 : TO;
            e_perf[k] = run_len;
            for (int c = t; c < t + run_len; c++) begin
               e_start[c] = 3'b001 << k; e_cur[c] = 3'(k); e_busy[c] = 1'b1;
            end
            if (d[k] < TO) begin
               sdone[t + d[k]][k] = 1'b1;
               if (k == LS) latch_c = t + d[k];
               e_busy[t + run_len] = 1'b1;
               t = t + run_len + 1;
            end else begin
               for (int c = t + TO; c < H; c++) begin
                  e_err[c] = 1'b1; e_errst[c] = 2'(k);
               end
               stopped = 1'b1;
            end
         end
      end
      if (!stopped) begin
         e_busy[t] = 1'b1; e_done[t] = 1'b1;
      end
      for (int c = 0; c < H; c++) begin
         e_cnt[c] = (latch_c >= 0 && c > latch_c) ? cin[latch_c] : m_count;
      end
      if (abort_at >= 0) begin
         ab[abort_at] = 1'b1;
         for (int c = abort_at + 1; c < H; c++) begin
            e_start[c] = 3'b000; e_cur[c] = NONE; e_busy[c] = 1'b0; e_done[c] = 1'b0;
            e_err[c] = 1'b0; e_cnt[c] = e_cnt[abort_at];
         end
      end
      if (noise) begin
         for (int c = 1; c < H; c++) begin
            for (int j = 0; j < NS; j++) begin
               if (e_cur[c] != 3'(j) && $urandom_range(0, 3) == 0) sdone[c][j] = 1'b1;
            end
            if (e_busy[c] && $urandom_range(0, 2) == 0) st[c] = 1'b1;
         end
      end

      for (int b = 0; b < NS*NM*AW; b++) saddr[b] = 1'($urandom);
      for (int b = 0; b < NS*NM; b++) swe[b] = 1'($urandom);
      if (pin_mux) begin
         for (int b = 0; b < NS*NM; b++) begin
            saddr[b*AW +: AW] = 9'h0FF; swe[b] = 1'b1;
         end
         for (int m = 0; m < NM; m++) swe[NM + m] = (m == 2);
         saddr[(NM + 2)*AW +: AW] = 9'h1A5;
      end
      bus.stage_addr = saddr;
      bus.stage_we   = swe;

      for (int c = 0; c < H; c++) begin
         @(posedge clk); #1;
         start = st[c]; abort = ab[c]; stage_mask = mk[c]; count_in = cin[c];
         bus.stage_done = sdone[c];
         @(negedge clk);
         xa = '0; xw = '0;
         if (e_cur[c] != NONE) begin
            ec = int'(e_cur[c]);
            for (int m = 0; m < NM; m++) begin
               xa[m*AW +: AW] = saddr[(ec*NM + m)*AW +: AW];
               xw[m] = swe[ec*NM + m];
            end
         end
         sfx = $sformatf("s%0d.c%0d", sc, c);
         check_eq({"stage_start ", sfx}, 64'(bus.stage_start), 64'(e_start[c]));
         check_eq({"cur_stage ", sfx}, 64'(cur_stage), 64'(e_cur[c]));
         check_eq({"busy ", sfx}, 64'(busy), 64'(e_busy[c]));
         check_eq({"done ", sfx}, 64'(done), 64'(e_done[c]));
         check_eq({"error ", sfx}, 64'(error), 64'(e_err[c]));
         if (e_err[c]) check_eq({"err_stage ", sfx}, 64'(err_stage), 64'(e_errst[c]));
         check_eq({"count_out ", sfx}, 64'(count_out), 64'(e_cnt[c]));
         check_eq({"mem_addr ", sfx}, 64'(bus.mem_addr), 64'(xa));
         check_eq({"mem_we ", sfx}, 64'(bus.mem_we), 64'(xw));
      end
`ifdef SIFT_SEQ_PERF_EN
      if (abort_at < 0) begin
         for (int k = 0; k < NS; k++)
            check_eq($sformatf("perf s%0d k%0d", sc, k), 64'(perf_cycles[k*32 +: 32]),
                     64'(e_perf[k]));
      end
`endif
      start = 1'b0; abort = 1'b0; bus.stage_done = '0;
      m_err = e_err[H-1]; m_errst = e_errst[H-1]; m_count = e_cnt[H-1];
      sc++;
   endtask

   initial begin
      logic [2:0] rm;
      int rd [NS];
      int rab;

      bus.stage_done = '0;
      bus.stage_addr = '0;
      bus.stage_we   = '1;
      #23;
      check_eq("reset stage_start", 64'(bus.stage_start), 64'(0));
      check_eq("reset cur_stage", 64'(cur_stage), 64'(NONE));
      check_eq("reset busy", 64'(busy), 64'(0));
      check_eq("reset done", 64'(done), 64'(0));
      check_eq("reset error", 64'(error), 64'(0));
      check_eq("reset count_out", 64'(count_out), 64'(0));
      check_eq("reset mem_we", 64'(bus.mem_we), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      run_scenario(3'b111, 5, 5, 5, -1, 1'b0, 1'b0, -1);
      run_scenario(3'b101, 4, 4, 6, -1, 1'b0, 1'b0, 417);
      run_scenario(3'b010, 0, 7, 0, -1, 1'b0, 1'b0, 417);
      check_eq("count_417", 64'(count_out), 64'(417));
      run_scenario(3'b010, 0, 6, 0, -1, 1'b0, 1'b1, -1);
      run_scenario(3'b001, 30, 0, 0, -1, 1'b0, 1'b0, -1);
      check_eq("wd error", 64'(error), 64'(1));
      run_scenario(3'b001, 3, 0, 0, -1, 1'b0, 1'b0, -1);
      run_scenario(3'b111, 3, 4, 3, 10, 1'b0, 1'b0, -1);
      run_scenario(3'b000, 0, 0, 0, -1, 1'b0, 1'b0, -1);
      run_scenario(3'b001, 15, 0, 0, -1, 1'b0, 1'b0, -1);
      run_scenario(3'b110, 0, 20, 0, -1, 1'b0, 1'b0, -1);
      run_scenario(3'b111, 2, 2, 2, 0, 1'b0, 1'b0, -1);

      for (int i = 0; i < 24; i++) begin
         rm = 3'($urandom_range(0, 7));
         for (int k = 0; k < NS; k++)
            rd[k] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 24))
                                                : int'($urandom_range(0, 12));
         rab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
         run_scenario(rm, rd[0], rd[1], rd[2], rab, 1'b1, 1'b0, -1);
      end

      // Asynchronous reset in the middle of a stage.
      bus.stage_we = '1; bus.stage_done = '0;
      @(posedge clk); #1;
      start = 1'b1; abort = 1'b0; stage_mask = 3'b001;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check_eq("pre-reset stage_start", 64'(bus.stage_start), 64'(3'b001));
      check_eq("pre-reset mem_we", 64'(bus.mem_we), 64'(4'hF));
      #2 rst_n = 1'b0;
      #1;
      check_eq("async stage_start", 64'(bus.stage_start), 64'(0));
      check_eq("async mem_we", 64'(bus.mem_we), 64'(0));
      check_eq("async cur_stage", 64'(cur_stage), 64'(NONE));
      check_eq("async busy", 64'(busy), 64'(0));
      check_eq("async count_out", 64'(count_out), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      m_err = 1'b0; m_errst = 2'd0; m_count = '0;
      run_scenario(3'b111, 2, 2, 2, -1, 1'b0, 1'b0, 55);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sift_stage_sequencer.md
Name: sift_stage_sequencer

Overview:
- Parametrised top-level stage sequencer for the SIFT pipeline (blur → detect/filter → descriptor/match and future stages).
- Starts each enabled stage in order using a start/done handshake.
- Muxes the active stage's shared-memory address and write-enable buses onto the memories.
- Latches a per-run count from a designated stage, guards each stage with a watchdog, and returns to idle, unlike a terminal END state.

Parameters:
- NUM_STAGES, 3, number of sequenced stages; stage 0 runs first.
- NUM_MEMS, 4, number of shared memories whose address/we are muxed.
- ADDR_W, 9, address width per memory.
- CNT_W, 11, width of latched count (keypoint count).
- LATCH_STAGE, 1, stage whose done cycle latches count_in.
- TIMEOUT_CYCLES, 4194303, max cycles per stage; 0 disables watchdog.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request, sampled in IDLE/ERR only.
- abort  in  1  synchronous abort, highest priority.
- stage_mask  in  NUM_STAGES  1 = stage enabled; latched at start.
- stage_done  in  NUM_STAGES  per-stage done level/pulse.
- stage_addr  in  NUM_STAGES*NUM_MEMS*ADDR_W  flattened: stage s, mem m at [(s*NUM_MEMS+m)*ADDR_W +: ADDR_W].
- stage_we  in  NUM_STAGES*NUM_MEMS  flattened: stage s, mem m at bit s*NUM_MEMS+m.
- count_in  in  CNT_W  count presented by LATCH_STAGE.
- stage_start  out  NUM_STAGES  one-hot (or zero) level start, held through RUN.
- mem_addr  out  NUM_MEMS*ADDR_W  muxed addresses.
- mem_we  out  NUM_MEMS  muxed write enables.
- cur_stage  out  $clog2(NUM_STAGES)+1  active stage index; all-ones when none.
- count_out  out  CNT_W  latched count.
- busy  out  1  high in RUN/GAP/FIN.
- done  out  1  one-cycle pulse at end of run.
- error  out  1  watchdog fired; sticky until start or abort.
- err_stage  out  $clog2(NUM_STAGES)  stage that timed out.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except cur_stage = all-ones; mask register 0; watchdog 0.
- States: IDLE, RUN, GAP, FIN, ERR. Registered outputs; mem_addr/mem_we are combinational from the registered current stage.
- IDLE/ERR + start=1:
  - mask != 0: latch mask, k = lowest set bit, clear error, go RUN. stage_start[k]=1 the next cycle.
  - mask == 0: go FIN directly.
- RUN(k):
  - stage_start[k]=1, cur_stage=k; mem_addr/mem_we = stage k's slices; stage_done of other stages ignored.
  - stage_done[k]=1 → GAP next cycle. If k==LATCH_STAGE, count_out <= count_in on that edge.
- GAP (exactly 1 cycle):
  - stage_start=0, mem_we=0, mem_addr=0, cur_stage=all-ones; forces sub-blocks to re-arm.
  - Next enabled stage above k → RUN(that stage); none → FIN.
- FIN (1 cycle): done=1, then IDLE. busy falls with FIN→IDLE.
- Latency:
  - start at cycle 0 → stage_start at cycle 1.
  - stage_done at cycle t → next stage_start at t+2.
  - Last stage done at t → done pulse at t+2.
- Watchdog:
  - Counter clears on RUN entry and increments each RUN cycle.
  - Reaching TIMEOUT_CYCLES without done → ERR: error=1, err_stage=k, stage_start=0, mem_we=0, busy=0.
  - ERR is held until start or abort.
  - Done and timeout in the same cycle: done wins.
- abort=1 in any state → IDLE next edge: stage_start=0, mem_we=0, no done pulse, error cleared, count_out retained. Abort beats start and done in the same cycle.
- start while busy is ignored; stage_mask changes mid-run have no effect.
- count_out persists across runs; it is updated only by LATCH_STAGE done.

Optional Feature:
- Macro SIFT_SEQ_PERF_EN.
- Defined:
  - Adds output perf_cycles, NUM_STAGES*32 bits: per-stage count of RUN cycles for the last run.
  - Each counter clears when its stage enters RUN and saturates at 2^32-1.
  - Skipped stages hold 0 for that run.
  - Cleared on reset.
- Undefined: port and counters are absent; all other behaviour is identical.

Test Plan:
- Full run: mask=3'b111, start pulse, each stage_done asserted 5 cycles after its stage_start → stage_start 001/010/100 in order, 1-cycle gaps, done pulse 2 cycles after stage 2 done, busy low afterwards.
- Skip and latch: mask=3'b101, count_in=11'd417 → stage 1 never started; count_out stays at its prior value. Then mask=3'b010, count_in=417 at done → count_out=417.
- Mux: in RUN(1), stage 1 mem 2 addr=9'h1A5 and we=1, other stages drive 9'h0FF → mem_addr mem 2 = 9'h1A5, mem_we[2]=1. In GAP, all mem_we=0.
- Watchdog: TIMEOUT_CYCLES=16, stage 0 never done → error=1 and err_stage=0 exactly 16 cycles after RUN entry, stage_start=0. Then start → error clears and stage 0 restarts.
- Abort/priority: abort and stage_done[1] in the same cycle → IDLE, no done pulse. mask=0 with start → done pulse next cycle with no stage_start.
- Async reset mid-RUN: rst_n low between clock edges → stage_start and mem_we drop immediately, state IDLE.
